// File: rtl/reorder_pkg.sv
// Shared types and helpers for the multi-bank reorder buffer.
//   bank_state_e : per-bank lifecycle (EMPTY -> FILL -> DRAIN -> EMPTY)
//   ptr_inc      : ring-pointer increment that wraps at an arbitrary bank count
package reorder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } bank_state_e;

  // Bank counts need not be powers of two, so the wrap is explicit.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned nb);
    return (ptr + 32'd1 >= nb) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One reorder bank: D-entry store, optional valid map, fill count, state and a
// synchronous read port (address in cycle n, data on rd_data_o in cycle n+1).
//
// Configuration macro: REORDER_MB_DUP_CHECK_EN
//   defined   - a write to an already-valid offset is flagged on dup_o and dropped
//   undefined - no valid map; every write stores and counts, so holes are possible
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   wr_en_i                   accepted write targeted at this bank
//   wr_offset_i, wr_data_i    write offset and data
//   rd_en_i, rd_idx_i         read issue and index (only while DRAIN)
//   state_o                   current bank state
//   rd_data_o                 registered read data
//   dup_o                     current write hits an already-valid offset
//   seal_o                    current write completes the frame
module reorder_bank
  import reorder_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_offset_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  output bank_state_e   state_o,
  output logic [DW-1:0] rd_data_o,
  output logic          dup_o,
  output logic          seal_o
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] CntFull = {1'b1, {AW{1'b0}}};

  bank_state_e   state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   count_inc;
  logic          wr_do;
  logic          rd_last;
  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rd_data_q;

`ifdef REORDER_MB_DUP_CHECK_EN
  logic [Depth-1:0] valid_q, valid_d;

  assign dup_o = wr_en_i && valid_q[wr_offset_i];

  always_comb begin
    valid_d = valid_q;
    if (wr_do) valid_d[wr_offset_i] = 1'b1;
    if (rd_last) valid_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end
`else
  assign dup_o = 1'b0;
`endif

  assign wr_do     = wr_en_i && !dup_o;
  assign rd_last   = rd_en_i && (rd_idx_i == {AW{1'b1}});
  assign count_inc = count_q + 1'b1;
  assign seal_o    = wr_do && (count_inc == CntFull);

  // Writes only arrive outside DRAIN and reads only inside it, so the two
  // updates below never collide.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (wr_do) begin
      count_d = count_inc;
      state_d = seal_o ? DRAIN : FILL;
    end
    if (rd_last) begin
      count_d = '0;
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Store and read register are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_do) mem_q[wr_offset_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign state_o   = state_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reorder_multibank.sv
// N-bank reorder buffer. Out-of-order words tagged with a frame offset fill the
// current bank; full banks seal and drain in offset order, in seal order.
//
// Configuration macro: REORDER_MB_DUP_CHECK_EN (duplicate-offset detection;
// without it err_dup is constant 0).
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if1_dut_data/offset/vld, dut_if1_rdy  unordered input handshake
//   dut_if2_data/vld, if2_dut_rdy         ordered output handshake
//   bank_busy                          bit k set when bank k is not EMPTY
//   err_dup                            one-cycle pulse after a duplicate accept
module reorder_multibank
  import reorder_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned NB = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] if1_dut_data,
  input  logic [AW-1:0] if1_dut_offset,
  input  logic          if1_dut_vld,
  output logic          dut_if1_rdy,
  output logic [DW-1:0] dut_if2_data,
  output logic          dut_if2_vld,
  input  logic          if2_dut_rdy,
  output logic [NB-1:0] bank_busy,
  output logic          err_dup
);

  localparam int unsigned PW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] IdxLast = {AW{1'b1}};

  bank_state_e   bank_state   [NB];
  logic [DW-1:0] bank_rd_data [NB];
  logic [NB-1:0] bank_wr_en, bank_rd_en, bank_dup, bank_seal;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  // Stage 1: a read issued to a bank whose data sits in that bank's read register.
  logic          s1_vld_q, s1_vld_d;
  logic [PW-1:0] s1_bank_q, s1_bank_d;
  logic          out_vld_q, out_vld_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          err_dup_q, err_dup_d;

  logic accept;
  logic out_load;
  logic rd_issue;

  assign dut_if1_rdy = (bank_state[wr_ptr_q] != DRAIN);
  assign accept      = if1_dut_vld && dut_if1_rdy;
  assign out_load    = !out_vld_q || if2_dut_rdy;
  // Only one read is ever in flight, so a bank's read register is never
  // overwritten before stage 1 hands it to the output register.
  assign rd_issue    = (bank_state[rd_ptr_q] == DRAIN) && (!s1_vld_q || out_load);

  for (genvar k = 0; k < NB; k++) begin : g_bank
    assign bank_wr_en[k] = accept && (wr_ptr_q == PW'(k));
    assign bank_rd_en[k] = rd_issue && (rd_ptr_q == PW'(k));
    assign bank_busy[k]  = (bank_state[k] != EMPTY);

    reorder_bank #(
      .DW (DW),
      .AW (AW)
    ) u_bank (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .wr_en_i     (bank_wr_en[k]),
      .wr_offset_i (if1_dut_offset),
      .wr_data_i   (if1_dut_data),
      .rd_en_i     (bank_rd_en[k]),
      .rd_idx_i    (rd_idx_q),
      .state_o     (bank_state[k]),
      .rd_data_o   (bank_rd_data[k]),
      .dup_o       (bank_dup[k]),
      .seal_o      (bank_seal[k])
    );
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_idx_d   = rd_idx_q;
    s1_vld_d   = rd_issue || (s1_vld_q && !out_load);
    s1_bank_d  = rd_issue ? rd_ptr_q : s1_bank_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    err_dup_d  = |bank_dup;

    if (|bank_seal) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), NB));

    if (rd_issue) begin
      if (rd_idx_q == IdxLast) begin
        rd_idx_d = '0;
        rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), NB));
      end else begin
        rd_idx_d = rd_idx_q + 1'b1;
      end
    end

    if (out_load) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) out_data_d = bank_rd_data[s1_bank_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_idx_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_bank_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      err_dup_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_idx_q   <= rd_idx_d;
      s1_vld_q   <= s1_vld_d;
      s1_bank_q  <= s1_bank_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      err_dup_q  <= err_dup_d;
    end
  end

  assign dut_if2_vld  = out_vld_q;
  assign dut_if2_data = out_data_q;
  assign err_dup      = err_dup_q;

endmodule

// File: tb/tb_reorder_multibank.sv
// Directed bench for reorder_multibank with DW=8, AW=2, NB=3.
// Honours REORDER_MB_DUP_CHECK_EN for the duplicate-offset scenario.
module tb_reorder_multibank;

  logic       clk;
  logic       rst_n;
  logic [7:0] if1_dut_data;
  logic [1:0] if1_dut_offset;
  logic       if1_dut_vld;
  logic       dut_if1_rdy;
  logic [7:0] dut_if2_data;
  logic       dut_if2_vld;
  logic       if2_dut_rdy;
  logic [2:0] bank_busy;
  logic       err_dup;

  int n_checks = 0;
  int n_errors = 0;

  reorder_multibank #(
    .DW (8),
    .AW (2),
    .NB (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if1_dut_data   (if1_dut_data),
    .if1_dut_offset (if1_dut_offset),
    .if1_dut_vld    (if1_dut_vld),
    .dut_if1_rdy    (dut_if1_rdy),
    .dut_if2_data   (dut_if2_data),
    .dut_if2_vld    (dut_if2_vld),
    .if2_dut_rdy    (if2_dut_rdy),
    .bank_busy      (bank_busy),
    .err_dup        (err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic push(input logic [1:0] off, input logic [7:0] d);
    int n = 0;
    if1_dut_vld    = 1'b1;
    if1_dut_offset = off;
    if1_dut_data   = d;
    while (!dut_if1_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_rdy", dut_if1_rdy, 1);
    @(posedge clk); #1;
    if1_dut_vld = 1'b0;
  endtask

  // Expects if2_dut_rdy=1. Waits (bounded) for a valid word, checks it, lets it pop.
  task automatic pop_check(input string tag, input logic [7:0] exp, input bit strict);
    int n = 0;
    while (!dut_if2_vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_vld"}, dut_if2_vld, 1);
    chk(tag, dut_if2_data, exp);
    if (strict) chk({tag, "_nobubble"}, n, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int         pat [4] = '{1, 0, 0, 1};
  int         idx;
  logic       pv;
  logic [7:0] pd;

  initial begin
    rst_n          = 1'b0;
    if1_dut_data   = '0;
    if1_dut_offset = '0;
    if1_dut_vld    = 1'b0;
    if2_dut_rdy    = 1'b1;
    #2;
    chk("rst_if1_rdy", dut_if1_rdy, 1);
    chk("rst_if2_vld", dut_if2_vld, 0);
    chk("rst_if2_data", dut_if2_data, 0);
    chk("rst_busy", bank_busy, 0);
    chk("rst_err_dup", err_dup, 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // In-order frame -> bank 0
    push(2'd0, 8'h10);
    chk("inord_busy", bank_busy, 3'b001);
    push(2'd1, 8'h11);
    push(2'd2, 8'h12);
    push(2'd3, 8'h13);
    chk("inord_lat0", dut_if2_vld, 0);
    @(posedge clk); #1;
    chk("inord_lat1", dut_if2_vld, 0);
    @(posedge clk); #1;
    chk("inord_lat2", dut_if2_vld, 1);
    pop_check("inord_w0", 8'h10, 1);
    pop_check("inord_w1", 8'h11, 1);
    pop_check("inord_w2", 8'h12, 1);
    pop_check("inord_w3", 8'h13, 1);
    chk("inord_done_vld", dut_if2_vld, 0);

    // Reverse order -> bank 1
    push(2'd3, 8'hA3);
    push(2'd2, 8'hA2);
    push(2'd1, 8'hA1);
    push(2'd0, 8'hA0);
    pop_check("rev_w0", 8'hA0, 0);
    pop_check("rev_w1", 8'hA1, 1);
    pop_check("rev_w2", 8'hA2, 1);
    pop_check("rev_w3", 8'hA3, 1);

    // Backpressure: three frames into banks 2, 0, 1 with the consumer stalled
    if2_dut_rdy = 1'b0;
    push(2'd2, 8'h22); push(2'd0, 8'h20); push(2'd3, 8'h23); push(2'd1, 8'h21);
    push(2'd1, 8'h31); push(2'd3, 8'h33); push(2'd0, 8'h30); push(2'd2, 8'h32);
    push(2'd3, 8'h43); push(2'd2, 8'h42); push(2'd1, 8'h41); push(2'd0, 8'h40);
    chk("bp_rdy_low", dut_if1_rdy, 0);
    chk("bp_busy", bank_busy, 3'b111);
    chk("bp_hold_vld", dut_if2_vld, 1);
    chk("bp_hold_data", dut_if2_data, 8'h20);
    if2_dut_rdy = 1'b1;
    pop_check("bp_a0", 8'h20, 1);
    chk("bp_rdy_still_low", dut_if1_rdy, 0);
    pop_check("bp_a1", 8'h21, 1);
    pop_check("bp_a2", 8'h22, 1);
    pop_check("bp_a3", 8'h23, 1);
    chk("bp_rdy_back", dut_if1_rdy, 1);
    for (int i = 0; i < 4; i++) pop_check("bp_b", 8'h30 + 8'(i), 1);
    for (int i = 0; i < 4; i++) pop_check("bp_c", 8'h40 + 8'(i), 1);
    chk("bp_busy_end", bank_busy, 3'b000);

    // Duplicate offset -> bank 2 (which still holds 0x20..0x23 from above)
    push(2'd0, 8'h50);
    push(2'd0, 8'hEE);
`ifdef REORDER_MB_DUP_CHECK_EN
    chk("dup_pulse", err_dup, 1);
    push(2'd1, 8'h51);
    chk("dup_pulse_end", err_dup, 0);
    push(2'd2, 8'h52);
    chk("dup_quiet", err_dup, 0);
    push(2'd3, 8'h53);
    pop_check("dup_w0", 8'h50, 0);
    pop_check("dup_w1", 8'h51, 1);
    pop_check("dup_w2", 8'h52, 1);
    pop_check("dup_w3", 8'h53, 1);
`else
    chk("dup_no_pulse", err_dup, 0);
    push(2'd1, 8'h51);
    chk("dup_no_pulse2", err_dup, 0);
    push(2'd2, 8'h52);
    // Fourth accept sealed the bank; offset 3 starts a partial frame in bank 0.
    chk("dup_sealed_busy", bank_busy, 3'b100);
    push(2'd3, 8'h53);
    pop_check("dup_w0", 8'hEE, 0);
    pop_check("dup_w1", 8'h51, 1);
    pop_check("dup_w2", 8'h52, 1);
    pop_check("dup_w3_stale", 8'h23, 1);
`endif

    // Reset mid-drain
    do_reset();
    push(2'd0, 8'h60); push(2'd1, 8'h61); push(2'd2, 8'h62); push(2'd3, 8'h63);
    pop_check("mrst_w0", 8'h60, 0);
    pop_check("mrst_w1", 8'h61, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", dut_if2_vld, 0);
    chk("mrst_data", dut_if2_data, 0);
    chk("mrst_busy", bank_busy, 0);
    chk("mrst_rdy", dut_if1_rdy, 1);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(2'd1, 8'h71); push(2'd0, 8'h70); push(2'd3, 8'h73); push(2'd2, 8'h72);
    pop_check("post_rst_w0", 8'h70, 0);
    pop_check("post_rst_w1", 8'h71, 1);
    pop_check("post_rst_w2", 8'h72, 1);
    pop_check("post_rst_w3", 8'h73, 1);

    // Stalled pop with ready pattern 1,0,0,1
    if2_dut_rdy = 1'b0;
    push(2'd0, 8'h80); push(2'd1, 8'h81); push(2'd2, 8'h82); push(2'd3, 8'h83);
    idx = 0;
    pv  = 1'b0;
    pd  = '0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      if2_dut_rdy = pat[c % 4][0];
      if (pv) begin
        chk("stall_hold_vld", dut_if2_vld, 1);
        chk("stall_hold_data", dut_if2_data, pd);
      end
      pv = dut_if2_vld && !if2_dut_rdy;
      pd = dut_if2_data;
      if (dut_if2_vld && if2_dut_rdy) begin
        chk("stall_pop", dut_if2_data, 8'h80 + 8'(idx));
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("stall_count", idx, 4);
    chk("stall_no_repeat", dut_if2_vld, 0);
    if2_dut_rdy = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
